// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin read scheduler that drains NUM_Q fifo_sync queues into one tagged valid/ready stream with burst-limited fairness.
module fifo_rr_sched #(
  parameter int NUM_Q    = 4,
  parameter int BITWIDTH = 8,
  parameter int BURST    = 4,
  parameter int QIDW     = $clog2(NUM_Q)
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iClr,
  input  logic [NUM_Q-1:0]          iQEmpty,
  input  logic [NUM_Q*BITWIDTH-1:0] iQData,
  output logic [NUM_Q-1:0]          oQEnR,
  output logic                      oValid,
  output logic [BITWIDTH-1:0]       oData,
  output logic [QIDW-1:0]           oQid,
  input  logic                      iReady
);
  localparam int BCW = $clog2(BURST + 1);
  logic [QIDW-1:0] cur, iq, gsel, idx, q0, q1;
  logic [BCW-1:0] burst;
  logic [1:0] occ;
  logic infl, pop, credit, any, use_cur, grant;
  logic [BITWIDTH-1:0] d0, d1, wd;
  logic [BITWIDTH-1:0] qd [NUM_Q];
  genvar k;
  generate
    for (k = 0; k < NUM_Q; k++) begin : g_unpack
      assign qd[k] = iQData[k*BITWIDTH +: BITWIDTH];
    end
  endgenerate
  assign wd = qd[iq];
  assign pop = oValid & iReady;
  assign credit = ({1'b0, occ} + {2'b0, infl}) < (3'd2 + {2'b0, pop});
  assign any = ~&iQEmpty;
  assign use_cur = !iQEmpty[cur] && burst < BCW'(BURST);
  assign grant = iRstN && !iClr && credit && any;
  // Descending scan so the nearest non-empty queue after cur wins; cur itself is last.
  always_comb begin
    gsel = cur;
    idx = '0;
    for (int i = NUM_Q; i >= 1; i--) begin
      idx = QIDW'((int'(cur) + i) % NUM_Q);
      if (!iQEmpty[idx]) gsel = idx;
    end
    if (use_cur) gsel = cur;
  end
  assign oQEnR = grant ? (NUM_Q'(1) << gsel) : '0;
  assign oValid = occ != 2'd0;
  assign oData = oValid ? d0 : '0;
  assign oQid = oValid ? q0 : '0;
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cur <= '0;
      burst <= '0;
      infl <= 1'b0;
      iq <= '0;
      occ <= '0;
      d0 <= '0;
      d1 <= '0;
      q0 <= '0;
      q1 <= '0;
    end else if (iClr) begin
      cur <= '0;
      burst <= '0;
      infl <= 1'b0;
      occ <= '0;
    end else begin
      infl <= grant;
      if (grant) begin
        iq <= gsel;
        if (use_cur) burst <= burst + BCW'(1);
        else begin
          cur <= gsel;
          burst <= BCW'(1);
        end
      end
      occ <= occ + 2'(infl) - 2'(pop);
      if (pop) begin
        d0 <= d1;
        q0 <= q1;
      end
      // Push slot is the post-pop tail; a later write to d0 overrides the shift.
      if (infl) begin
        if (occ - 2'(pop) == 2'd0) begin
          d0 <= wd;
          q0 <= iq;
        end else begin
          d1 <= wd;
          q1 <= iq;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched: randomized bench comparing the scheduler against a queue-level model of the FIFOs and the output stream.
module tb_fifo_rr_sched;
  localparam int NQ = 4, W = 8, B = 4;
  logic iClk = 0, iRstN = 0, iClr = 0, iReady = 0;
  logic [NQ-1:0] iQEmpty, oQEnR;
  logic [NQ*W-1:0] iQData;
  logic oValid;
  logic [W-1:0] oData;
  logic [1:0] oQid;
  int checks = 0, errors = 0;
  int fq [NQ][$];
  int fd [NQ];
  int eq [$];
  int cur = 0, burst = 0, iw = 0;
  bit infl = 0;

  fifo_rr_sched #(.NUM_Q(NQ), .BITWIDTH(W), .BURST(B)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iQEmpty(iQEmpty), .iQData(iQData),
    .oQEnR(oQEnR), .oValid(oValid), .oData(oData), .oQid(oQid), .iReady(iReady)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_q();
    for (int q = 0; q < NQ; q++) begin
      iQEmpty[q] = fq[q].size() == 0;
      iQData[q*W +: W] = W'(fd[q]);
    end
  endtask

  task automatic fill(input int q, input int n);
    for (int i = 0; i < n; i++) fq[q].push_back(int'($urandom_range(0, 255)));
  endtask

  task automatic model_reset();
    eq.delete();
    infl = 0;
    cur = 0;
    burst = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic step(input bit rdy, input bit clr);
    int g;
    bit pop, credit, any;
    logic [NQ-1:0] m;
    iReady = rdy;
    iClr = clr;
    drive_q();
    #3;
    pop = eq.size() > 0 && rdy;
    credit = (eq.size() + int'(infl) - int'(pop)) < 2;
    any = 0;
    for (int q = 0; q < NQ; q++) any |= fq[q].size() > 0;
    g = -1;
    if (!clr && credit && any) begin
      if (fq[cur].size() > 0 && burst < B) g = cur;
      else for (int i = 1; i <= NQ; i++) if (g < 0 && fq[(cur + i) % NQ].size() > 0) g = (cur + i) % NQ;
    end
    m = (g < 0) ? '0 : NQ'(1) << g;
    chk("qenr", oQEnR, m);
    chk("valid", oValid, eq.size() > 0);
    if (eq.size() > 0) begin
      chk("data", oData, eq[0] % 256);
      chk("qid", oQid, eq[0] / 256);
    end
    @(posedge iClk);
    #1;
    if (clr) model_reset();
    else begin
      if (pop) void'(eq.pop_front());
      if (infl) eq.push_back(iw);
      infl = g >= 0;
      if (g >= 0) begin
        fd[g] = fq[g].pop_front();
        iw = g * 256 + fd[g];
        if (g == cur && burst < B) burst++;
        else begin
          cur = g;
          burst = 1;
        end
      end
    end
  endtask

  task automatic rst_mid();
    iReady = 1;
    iClr = 0;
    drive_q();
    iRstN = 0;
    #1;
    chk("arst_valid", oValid, 0);
    chk("arst_data", oData, 0);
    chk("arst_qid", oQid, 0);
    chk("arst_qenr", oQEnR, 0);
    @(posedge iClk);
    #1;
    iRstN = 1;
    model_reset();
  endtask

  initial begin
    for (int q = 0; q < NQ; q++) fd[q] = 0;
    drive_q();
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_valid", oValid, 0);
    chk("rst_data", oData, 0);
    chk("rst_qid", oQid, 0);
    chk("rst_qenr", oQEnR, 0);
    iRstN = 1;
    fill(2, 6);
    repeat (10) step(1, 0);
    for (int q = 0; q < NQ; q++) fill(q, 8);
    repeat (40) step(1, 0);
    fill(0, 5);
    repeat (10) step(0, 0);
    repeat (10) step(1, 0);
    fill(3, 1);
    repeat (4) step(1, 0);
    fill(1, 1);
    fill(3, 1);
    repeat (6) step(1, 0);
    for (int q = 0; q < NQ; q++) fill(q, 3);
    repeat (3) step(1, 0);
    step(1, 1);
    repeat (15) step(1, 0);
    for (int q = 0; q < NQ; q++) fill(q, 4);
    repeat (5) step(1, 0);
    rst_mid();
    repeat (10) step(1, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) fill(int'($urandom_range(0, NQ - 1)), int'($urandom_range(1, 3)));
      if (n == 1500) begin
        fill(1, 2);
        rst_mid();
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    repeat (5) step(1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
